// File: rtl/fpu_op_issuer_pkg.sv
// ============================================================================
// Module : fpu_op_issuer_pkg
// Brief  : Shared FP formats, condition/status records and issuer FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_op_issuer_pkg;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        logic unordered;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } issuerState_t;

endpackage

`default_nettype wire

// File: rtl/fpu_op_fifo.sv
// ============================================================================
// Module : fpu_op_fifo
// Brief  : Synchronous FIFO of operand pairs with show-ahead head output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_op_fifo
    import fpu_op_issuer_pkg::*;
#(
    parameter type FP_T  = fp16_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  FP_T                        push_in1,
    input  FP_T                        push_in2,
    output FP_T                        head_in1,
    output FP_T                        head_in2,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    FP_T              r_mem1 [DEPTH];
    FP_T              r_mem2 [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign head_in1 = r_mem1[r_rd_ptr];
    assign head_in2 = r_mem2[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem1[r_wr_ptr] <= push_in1;
            r_mem2[r_wr_ptr] <= push_in2;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_op_issuer.sv
// ============================================================================
// Module : fpu_op_issuer
// Brief  : Queues operand pairs and drives one multi-cycle FPU op at a time.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_op_issuer
    import fpu_op_issuer_pkg::*;
#(
    parameter type FP_T    = fp16_t,
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          opValid,
    output logic          opReady,
    input  FP_T           opIn1,
    input  FP_T           opIn2,
    output logic          unitReset,
    output logic          unitStart,
    output FP_T           unitIn1,
    output FP_T           unitIn2,
    input  FP_T           unitOut,
    input  logic          unitDone,
    input  condCode_t     unitCondCodes,
    input  opStatusFlag_t unitStatus,
    output logic          resValid,
    input  logic          resReady,
    output FP_T           resOut,
    output condCode_t     resCondCodes,
    output opStatusFlag_t resStatus,
    output logic          resTimeout,
    output logic          busy
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int WD_W  = $clog2(TIMEOUT+1);

    issuerState_t     r_state;
    issuerState_t     w_next;
    FP_T              r_in1;
    FP_T              r_in2;
    FP_T              r_res;
    condCode_t        r_codes;
    opStatusFlag_t    r_status;
    logic             r_timeout;
    logic [WD_W-1:0]  r_wdog;
    logic             w_wdog_expired;

    FP_T              w_head1;
    FP_T              w_head2;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;

    assign w_push         = opValid && opReady;
    assign w_pop          = (r_state == CLR);
    assign w_wdog_expired = (r_wdog == WD_W'(TIMEOUT-1));

    fpu_op_fifo #(
        .FP_T  (FP_T),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .push_in1 (opIn1),
        .push_in2 (opIn2),
        .head_in1 (w_head1),
        .head_in2 (w_head2),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next = CLR;
            CLR:     w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (unitDone || w_wdog_expired) w_next = HOLD;
            HOLD:    if (resReady) w_next = w_empty ? IDLE : CLR;
            default: w_next = IDLE;
        endcase
    end

    // Done arriving during LAUNCH is not looked at: only WAIT captures.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in1     <= '0;
            r_in2     <= '0;
            r_wdog    <= '0;
            r_res     <= '0;
            r_codes   <= '0;
            r_status  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                CLR: begin
                    r_in1  <= w_head1;
                    r_in2  <= w_head2;
                    r_wdog <= '0;
                end
                WAIT: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (unitDone) begin
                        r_res     <= unitOut;
                        r_codes   <= unitCondCodes;
                        r_status  <= unitStatus;
                        r_timeout <= 1'b0;
                    end else if (w_wdog_expired) begin
                        r_res     <= '0;
                        r_codes   <= '0;
                        r_status  <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, not just after the edge.
    always_comb begin
        opReady      = 1'b0;
        unitReset    = 1'b1;
        unitStart    = 1'b0;
        unitIn1      = '0;
        unitIn2      = '0;
        resValid     = 1'b0;
        resOut       = '0;
        resCondCodes = '0;
        resStatus    = '0;
        resTimeout   = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            opReady      = !w_full;
            unitReset    = (r_state == CLR);
            unitStart    = (r_state == LAUNCH);
            unitIn1      = r_in1;
            unitIn2      = r_in2;
            resValid     = (r_state == HOLD);
            resOut       = r_res;
            resCondCodes = r_codes;
            resStatus    = r_status;
            resTimeout   = r_timeout;
            busy         = (r_state != IDLE) || (w_count != '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_issuer.sv
// ============================================================================
// Module : tb_fpu_op_issuer
// Brief  : Directed bench for fpu_op_issuer with a behavioural FPU stub.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_op_issuer;
    import fpu_op_issuer_pkg::*;

    logic          clock;
    logic          reset;
    logic          opValid;
    logic          opReady;
    logic [15:0]   opIn1;
    logic [15:0]   opIn2;
    logic          unitReset;
    logic          unitStart;
    logic [15:0]   unitIn1;
    logic [15:0]   unitIn2;
    logic [15:0]   unitOut;
    logic          unitDone;
    condCode_t     unitCondCodes;
    opStatusFlag_t unitStatus;
    logic          resValid;
    logic          resReady;
    logic [15:0]   resOut;
    condCode_t     resCondCodes;
    opStatusFlag_t resStatus;
    logic          resTimeout;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_op_issuer #(
        .FP_T    (fp16_t),
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .opValid       (opValid),
        .opReady       (opReady),
        .opIn1         (opIn1),
        .opIn2         (opIn2),
        .unitReset     (unitReset),
        .unitStart     (unitStart),
        .unitIn1       (unitIn1),
        .unitIn2       (unitIn2),
        .unitOut       (unitOut),
        .unitDone      (unitDone),
        .unitCondCodes (unitCondCodes),
        .unitStatus    (unitStatus),
        .resValid      (resValid),
        .resReady      (resReady),
        .resOut        (resOut),
        .resCondCodes  (resCondCodes),
        .resStatus     (resStatus),
        .resTimeout    (resTimeout),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stub unit: result = in1+in2, codes = in1[3:0], flags = in2[4:0].
    // mode 0: done 3 cycles after start; 1: never done;
    // mode 2: bogus done during the start cycle, real done 5 cycles after start.
    int          mode = 0;
    logic        stub_act;
    logic [3:0]  stub_cnt;
    logic [15:0] stub_a;
    logic [15:0] stub_b;

    always @(posedge clock) begin
        if (unitReset) begin
            stub_act <= 1'b0;
            stub_cnt <= 4'd0;
        end else if (unitStart) begin
            stub_act <= 1'b1;
            stub_cnt <= 4'd0;
            stub_a   <= unitIn1;
            stub_b   <= unitIn2;
        end else if (stub_act && unitDone) begin
            stub_act <= 1'b0;
        end else if (stub_act) begin
            stub_cnt <= stub_cnt + 4'd1;
        end
    end

    assign unitDone = (mode == 0 && stub_act && stub_cnt == 4'd2) ||
                      (mode == 2 && (unitStart || (stub_act && stub_cnt == 4'd4)));
    assign unitOut       = (mode == 2 && unitStart) ? 16'hDEAD : stub_a + stub_b;
    assign unitCondCodes = condCode_t'(stub_a[3:0]);
    assign unitStatus    = opStatusFlag_t'(stub_b[4:0]);

    // Passive monitor: accepted results, start pulses, and an occupancy model.
    logic [15:0] res_q [$];
    int start_cnt  = 0;
    int start_viol = 0;
    int ready_err  = 0;
    int model_cnt  = 0;
    int full_seen  = 0;

    always @(negedge clock) begin
        if (unitStart) start_cnt++;
        if (unitStart && resValid) start_viol++;
        if (resValid && resReady) res_q.push_back(resOut);
        if (reset) begin
            model_cnt = 0;
        end else begin
            if (opReady !== (model_cnt < 4)) ready_err++;
            if (!opReady) full_seen = 1;
            if (opValid && opReady) model_cnt++;
            if (unitReset) model_cnt--;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        opValid = 1'b1;
        opIn1   = a;
        opIn2   = b;
        while (!opReady && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!unitStart && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!resValid && n < 100) begin
            tick();
            n++;
        end
    endtask

    logic [15:0] exp_a [5] = '{16'h0100, 16'h1111, 16'h7000, 16'hFFFF, 16'h1234};
    logic [15:0] exp_b [5] = '{16'h0200, 16'h2222, 16'h1000, 16'h0002, 16'h4321};
    logic [15:0] exp_r [5] = '{16'h0300, 16'h3333, 16'h8000, 16'h0001, 16'h5555};

    initial begin
        int n;
        int s0;
        int unstable;

        reset    = 1'b1;
        opValid  = 1'b0;
        opIn1    = '0;
        opIn2    = '0;
        resReady = 1'b1;
        tick();
        tick();

        chk("rst_unitReset", unitReset, 1);
        chk("rst_opReady", opReady, 0);
        chk("rst_unitStart", unitStart, 0);
        chk("rst_resValid", resValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resOut", resOut, 0);
        chk("rst_unitIn1", unitIn1, 0);

        reset = 1'b0;
        tick();
        chk("idle_opReady", opReady, 1);
        chk("idle_unitReset", unitReset, 0);
        chk("idle_busy", busy, 0);

        // Single op; push edge N -> start pulse in cycle N+2.
        push(16'h8FE3, 16'hA3CC);
        opValid = 1'b0;
        chk("t1_busy", busy, 1);
        wait_start(n);
        chk("t1_start_latency", n, 2);
        chk("t1_unitIn1", unitIn1, 16'h8FE3);
        chk("t1_unitIn2", unitIn2, 16'hA3CC);
        wait_res(n);
        chk("t1_done_latency", n, 4);
        chk("t1_resOut", resOut, 16'h33AF);
        chk("t1_codes", resCondCodes, 4'h3);
        chk("t1_status", resStatus, 5'h0C);
        chk("t1_timeout", resTimeout, 0);
        tick();
        chk("t1_single_pulse", resValid, 0);
        chk("t1_busy_after", busy, 0);

        // Back-pressure: result must hold and no new start until accepted.
        resReady = 1'b0;
        push(16'h0001, 16'h0002);
        push(16'h0010, 16'h0020);
        opValid = 1'b0;
        wait_res(n);
        chk("t3_first_valid", resValid, 1);
        s0       = start_cnt;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resValid !== 1'b1 || resOut !== 16'h0003 ||
                resCondCodes !== 4'h1 || resStatus !== 5'h02) unstable++;
        end
        chk("t3_stable_cycles_bad", unstable, 0);
        chk("t3_no_new_start", start_cnt - s0, 0);
        resReady = 1'b1;
        tick();
        chk("t3_valid_drop", resValid, 0);
        chk("t3_direct_clr", unitReset, 1);
        wait_res(n);
        chk("t3_second_res", resOut, 16'h0030);

        // Five pairs back-to-back; FIFO fills to DEPTH once.
        tick();
        res_q.delete();
        for (int i = 0; i < 5; i++) push(exp_a[i], exp_b[i]);
        opValid = 1'b0;
        n = 0;
        while (res_q.size() < 5 && n < 300) begin
            tick();
            n++;
        end
        chk("t2_result_count", res_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < res_q.size()) chk($sformatf("t2_order_%0d", i), res_q[i], exp_r[i]);
        chk("t2_full_seen", full_seen, 1);

        // Watchdog abort then normal follow-up op.
        mode = 1;
        push(16'hAAAA, 16'h5555);
        opValid = 1'b0;
        wait_start(n);
        wait_res(n);
        chk("t4_timeout_gap", n, 9);
        chk("t4_resTimeout", resTimeout, 1);
        chk("t4_resOut", resOut, 0);
        chk("t4_codes", resCondCodes, 0);
        chk("t4_status", resStatus, 0);
        mode = 0;
        push(16'h0005, 16'h0006);
        opValid = 1'b0;
        wait_res(n);
        chk("t4_next_res", resOut, 16'h000B);
        chk("t4_next_timeout", resTimeout, 0);

        // Reset during WAIT with three ops queued drops everything.
        tick();
        mode = 1;
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'h0001);
        opValid = 1'b0;
        tick();
        tick();
        res_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_resValid", resValid, 0);
        chk("t5_opReady_empty", opReady, 1);
        mode = 0;
        s0   = start_cnt;
        for (int i = 0; i < 30; i++) tick();
        chk("t5_no_results", res_q.size(), 0);
        chk("t5_no_starts", start_cnt - s0, 0);

        // Done during LAUNCH is ignored; real done comes later.
        mode = 2;
        push(16'h0003, 16'h0004);
        opValid = 1'b0;
        wait_start(n);
        wait_res(n);
        chk("t6_gap", n, 6);
        chk("t6_resOut", resOut, 16'h0007);
        chk("t6_codes", resCondCodes, 4'h3);
        chk("t6_status", resStatus, 5'h04);
        tick();
        tick();

        chk("start_during_valid", start_viol, 0);
        chk("opReady_vs_model", ready_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
